lupdate_gen: RTL and testbench

- Transmit-side counterpart of the local beacon-update receiver.
- Builds the 13-beat beacon update message (message type 4'hf) addressed to one remote node's MAC. That node's update logic extracts direction, token bucket parameter, direct MAC and time slot period from the message.
- Sits on the controller/master node and drives the 134-bit pkt bus toward the switch egress.

---
 rtl/lupdate_gen.sv | 252 +++++++++++++++++++++++++
 tb/tb_lupdate_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lupdate_gen.sv
// ---------------------------------------------------------------------------
// lupdate_gen
//
// Builds and transmits the 13-beat beacon update message (message type 4'hf)
// toward one remote node. The remote node's update logic picks direction,
// token bucket parameter, direct MAC and time slot period out of beat 6.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_lg_trigger              one-cycle request to send an update
//   in_lg_dst_mac              target node MAC
//   in_lg_direction            config: direction
//   in_lg_token_bucket_para    config: token bucket parameter
//   in_lg_direct_mac_addr      config: direct MAC address
//   in_lg_time_slot_period     config: time slot period
//   in_local_mac_id            source MAC of this node
//   in_lg_alf                  downstream almost-full, gates packet start only
//   out_lg_data                134-bit beat ([133:132] 01 head/11 mid/10 tail)
//   out_lg_data_wr             beat write strobe
//   out_lg_data_valid          packet-valid flag, on the tail beat
//   out_lg_data_valid_wr       valid write strobe, on the tail beat
//   out_lg_busy                packet pending, waiting or in flight
//   out_lg_done                one-cycle pulse on the tail beat
//   out_lg_seq                 sequence number of the last packet sent
//
// States
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE_S | nothing in flight; accepts a trigger or a pending request
//   WAIT_S | request latched, holding off while in_lg_alf is high
//   SEND_S | emitting beats 0..12 back to back, never stalled
// ---------------------------------------------------------------------------
module lupdate_gen #(
    parameter logic [7:0]  LMID     = 8'd13,
    parameter logic [15:0] ETH_TYPE = 16'h1662
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_lg_trigger,
    input  logic [47:0]   in_lg_dst_mac,
    input  logic          in_lg_direction,
    input  logic [31:0]   in_lg_token_bucket_para,
    input  logic [47:0]   in_lg_direct_mac_addr,
    input  logic [31:0]   in_lg_time_slot_period,
    input  logic [47:0]   in_local_mac_id,
    input  logic          in_lg_alf,
    output logic [133:0]  out_lg_data,
    output logic          out_lg_data_wr,
    output logic          out_lg_data_valid,
    output logic          out_lg_data_valid_wr,
    output logic          out_lg_busy,
    output logic          out_lg_done,
    output logic [14:0]   out_lg_seq
);

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        WAIT_S = 2'd1,
        SEND_S = 2'd2
    } state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic        direction;
        logic [31:0] tbp;
        logic [47:0] dmac;
        logic [31:0] tsp;
        logic [47:0] local_mac;
    } cfg_t;

    localparam logic [3:0]  LAST_BEAT = 4'd12;
    localparam logic [3:0]  MSG_TYPE  = 4'hf;
    localparam logic [11:0] BYTE_LEN  = 12'd208;

    localparam logic [1:0]  HDR_HEAD  = 2'b01;
    localparam logic [1:0]  HDR_MID   = 2'b11;
    localparam logic [1:0]  HDR_TAIL  = 2'b10;

    state_t        state_q,    state_d;
    logic [3:0]    beat_q,     beat_d;
    cfg_t          cfg_q,      cfg_d;
    logic          pend_q,     pend_d;
    cfg_t          pend_cfg_q, pend_cfg_d;
    logic [14:0]   seq_q,      seq_d;
    logic [133:0]  data_q,     data_d;
    logic          wr_q,       wr_d;
    logic          tail_q,     tail_d;
    logic          busy_q,     busy_d;

    cfg_t          trig_cfg;
    logic          start;
    logic [14:0]   seq_next;

    assign trig_cfg = '{
        dst_mac:   in_lg_dst_mac,
        direction: in_lg_direction,
        tbp:       in_lg_token_bucket_para,
        dmac:      in_lg_direct_mac_addr,
        tsp:       in_lg_time_slot_period,
        local_mac: in_local_mac_id
    };

    assign seq_next = seq_q + 15'd1;

    // ------------------------------------------------------------------
    // Next-state, request capture and sequence tracking
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cfg_d      = cfg_q;
        pend_d     = pend_q;
        pend_cfg_d = pend_cfg_q;
        seq_d      = seq_q;
        start      = 1'b0;

        // Any trigger that arrives while a packet is waiting or in flight,
        // including on the tail beat, is parked; a later one overwrites it.
        if ((state_q != IDLE_S) && in_lg_trigger) begin
            pend_d     = 1'b1;
            pend_cfg_d = trig_cfg;
        end

        case (state_q)
            IDLE_S: begin
                // A fresh trigger supersedes a parked request.
                if (in_lg_trigger) begin
                    cfg_d = trig_cfg;
                    start = 1'b1;
                end else if (pend_q) begin
                    cfg_d = pend_cfg_q;
                    start = 1'b1;
                end
                if (start) begin
                    pend_d  = 1'b0;
                    beat_d  = '0;
                    state_d = in_lg_alf ? WAIT_S : SEND_S;
                end
            end
            WAIT_S: begin
                if (!in_lg_alf) begin
                    state_d = SEND_S;
                    beat_d  = '0;
                end
            end
            SEND_S: begin
                // Leaving through IDLE_S gives the one idle cycle between
                // a tail and the next head.
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE_S;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE_S;
                beat_d  = '0;
            end
        endcase

        if ((state_d == SEND_S) && (beat_d == LAST_BEAT)) begin
            seq_d = seq_next;
        end
    end

    // ------------------------------------------------------------------
    // Output beat formation. Outputs are registered from the next-state
    // values so beat 0 appears in the cycle right after the trigger.
    // ------------------------------------------------------------------
    always_comb begin
        data_d = '0;
        wr_d   = 1'b0;
        tail_d = 1'b0;
        busy_d = (state_d != IDLE_S) || pend_d;

        if (state_d == SEND_S) begin
            wr_d   = 1'b1;
            tail_d = (beat_d == LAST_BEAT);

            if (beat_d == 4'd0) begin
                data_d[133:132] = HDR_HEAD;
            end else if (beat_d == LAST_BEAT) begin
                data_d[133:132] = HDR_TAIL;
            end else begin
                data_d[133:132] = HDR_MID;
            end

            case (beat_d)
                4'd0: begin
                    data_d[127:120] = LMID;
                    data_d[107:96]  = BYTE_LEN;
                end
                4'd2: begin
                    data_d[127:80] = cfg_d.dst_mac;
                    data_d[79:32]  = cfg_d.local_mac;
                    data_d[31:16]  = ETH_TYPE;
                    data_d[11:8]   = MSG_TYPE;
                end
                4'd6: begin
                    // Seq field carries the number this packet will own
                    // once its tail goes out.
                    data_d[127:80] = cfg_d.dmac;
                    data_d[79]     = cfg_d.direction;
                    data_d[78:64]  = seq_next;
                    data_d[63:32]  = cfg_d.tbp;
                    data_d[31:0]   = cfg_d.tsp;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_S;
            beat_q     <= '0;
            cfg_q      <= '0;
            pend_q     <= 1'b0;
            pend_cfg_q <= '0;
            seq_q      <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            tail_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cfg_q      <= cfg_d;
            pend_q     <= pend_d;
            pend_cfg_q <= pend_cfg_d;
            seq_q      <= seq_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            tail_q     <= tail_d;
            busy_q     <= busy_d;
        end
    end

    assign out_lg_data          = data_q;
    assign out_lg_data_wr       = wr_q;
    assign out_lg_data_valid    = tail_q;
    assign out_lg_data_valid_wr = tail_q;
    assign out_lg_done          = tail_q;
    assign out_lg_busy          = busy_q;
    assign out_lg_seq           = seq_q;

endmodule

// File: tb/tb_lupdate_gen.sv
module tb_lupdate_gen;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_lg_trigger;
    logic [47:0]   in_lg_dst_mac;
    logic          in_lg_direction;
    logic [31:0]   in_lg_token_bucket_para;
    logic [47:0]   in_lg_direct_mac_addr;
    logic [31:0]   in_lg_time_slot_period;
    logic [47:0]   in_local_mac_id;
    logic          in_lg_alf;
    logic [133:0]  out_lg_data;
    logic          out_lg_data_wr;
    logic          out_lg_data_valid;
    logic          out_lg_data_valid_wr;
    logic          out_lg_busy;
    logic          out_lg_done;
    logic [14:0]   out_lg_seq;

    always #5 clk = ~clk;

    lupdate_gen dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_lg_trigger           (in_lg_trigger),
        .in_lg_dst_mac           (in_lg_dst_mac),
        .in_lg_direction         (in_lg_direction),
        .in_lg_token_bucket_para (in_lg_token_bucket_para),
        .in_lg_direct_mac_addr   (in_lg_direct_mac_addr),
        .in_lg_time_slot_period  (in_lg_time_slot_period),
        .in_local_mac_id         (in_local_mac_id),
        .in_lg_alf               (in_lg_alf),
        .out_lg_data             (out_lg_data),
        .out_lg_data_wr          (out_lg_data_wr),
        .out_lg_data_valid       (out_lg_data_valid),
        .out_lg_data_valid_wr    (out_lg_data_valid_wr),
        .out_lg_busy             (out_lg_busy),
        .out_lg_done             (out_lg_done),
        .out_lg_seq              (out_lg_seq)
    );

    typedef struct packed {
        logic [47:0] dst;
        logic        dir;
        logic [31:0] tbp;
        logic [47:0] dmac;
        logic [31:0] tsp;
        logic [47:0] lmac;
    } req_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Message image for one beat, written straight from the field layout.
    function automatic logic [133:0] beat_val(input int i, input req_t c, input logic [14:0] s);
        logic [14:0] sp1;
        sp1 = s + 15'd1;
        case (i)
            0:  return {2'b01, 4'h0, 8'd13, 12'h0, 12'd208, 96'h0};
            2:  return {2'b11, 4'h0, c.dst, c.lmac, 16'h1662, 4'h0, 4'hf, 8'h0};
            6:  return {2'b11, 4'h0, c.dmac, c.dir, sp1, c.tbp, c.tsp};
            12: return {2'b10, 132'h0};
            default: return {2'b11, 132'h0};
        endcase
    endfunction

    // Reference model: a packet in flight (position of the beat on the
    // output, -1 for none), a request held back by alf, one parked request
    // slot, and the count of tails sent.
    int          m_pos  = -1;
    bit          m_wait = 1'b0;
    bit          m_pend = 1'b0;
    req_t        m_cfg  = '0;
    req_t        m_pcfg = '0;
    logic [14:0] m_seq  = '0;
    bit          preload_now = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  = -1;
            m_wait = 1'b0;
            m_pend = 1'b0;
            m_cfg  = '0;
            m_pcfg = '0;
            m_seq  = '0;
        end else begin
            req_t ic;
            ic = '{dst: in_lg_dst_mac, dir: in_lg_direction, tbp: in_lg_token_bucket_para,
                   dmac: in_lg_direct_mac_addr, tsp: in_lg_time_slot_period, lmac: in_local_mac_id};
            if (preload_now) m_seq = 15'h7ffe;
            if (m_pos >= 0) begin
                if (in_lg_trigger) begin m_pend = 1'b1; m_pcfg = ic; end
                if (m_pos == 12) m_pos = -1;
                else m_pos = m_pos + 1;
            end else if (m_wait) begin
                if (in_lg_trigger) begin m_pend = 1'b1; m_pcfg = ic; end
                if (!in_lg_alf) begin m_wait = 1'b0; m_pos = 0; end
            end else if (in_lg_trigger || m_pend) begin
                m_cfg  = in_lg_trigger ? ic : m_pcfg;
                m_pend = 1'b0;
                if (in_lg_alf) m_wait = 1'b1;
                else m_pos = 0;
            end
            if (m_pos == 12) m_seq = m_seq + 15'd1;
        end
    end

    always @(negedge clk) begin
        logic [133:0] e_data;
        logic         e_wr, e_tail, e_busy;
        e_data = (m_pos >= 0) ? beat_val(m_pos, m_cfg, m_seq) : '0;
        e_wr   = (m_pos >= 0);
        e_tail = (m_pos == 12);
        e_busy = (m_pos >= 0) || m_wait || m_pend;
        chk("m_data",     out_lg_data, e_data);
        chk("m_wr",       {133'h0, out_lg_data_wr}, {133'h0, e_wr});
        chk("m_valid",    {133'h0, out_lg_data_valid}, {133'h0, e_tail});
        chk("m_valid_wr", {133'h0, out_lg_data_valid_wr}, {133'h0, e_tail});
        chk("m_done",     {133'h0, out_lg_done}, {133'h0, e_tail});
        chk("m_busy",     {133'h0, out_lg_busy}, {133'h0, e_busy});
        chk("m_seq",      {119'h0, out_lg_seq}, {119'h0, m_seq});
    end

    task automatic tick(input bit trig, input bit alf);
        in_lg_trigger = trig;
        in_lg_alf     = alf;
        @(posedge clk);
        @(negedge clk);
        preload_now = 1'b0;
    endtask

    task automatic rand_cfg();
        in_lg_dst_mac           = {16'($urandom), 32'($urandom)};
        in_lg_direction         = 1'($urandom);
        in_lg_token_bucket_para = 32'($urandom);
        in_lg_direct_mac_addr   = {16'($urandom), 32'($urandom)};
        in_lg_time_slot_period  = 32'($urandom);
        in_local_mac_id         = {16'($urandom), 32'($urandom)};
    endtask

    // Sends one packet from the trigger through its tail, checking the
    // beat-6 seq field and the seq after the tail against literals.
    task automatic send_one(input string tag, input logic [14:0] f6, input logic [14:0] s_after);
        tick(1'b1, 1'b0);
        chk({tag, "_head"}, {132'h0, out_lg_data[133:132]}, {132'h0, 2'b01});
        for (int b = 1; b <= 12; b++) begin
            tick(1'b0, 1'b0);
            if (b == 6) chk({tag, "_b6seq"}, {119'h0, out_lg_data[78:64]}, {119'h0, f6});
        end
        chk({tag, "_done"}, {133'h0, out_lg_done}, 134'd1);
        chk({tag, "_seq"},  {119'h0, out_lg_seq}, {119'h0, s_after});
        tick(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_lg_trigger = 1'b0;
        in_lg_alf = 1'b0;
        rand_cfg();
        @(negedge clk);
        chk("rst_data", out_lg_data, '0);
        chk("rst_busy", {133'h0, out_lg_busy}, '0);
        chk("rst_seq",  {119'h0, out_lg_seq}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);

        // Single send with hand-computed beats.
        in_lg_dst_mac           = 48'h0a0b0c0d0e0f;
        in_lg_direction         = 1'b1;
        in_lg_token_bucket_para = 32'h20;
        in_lg_direct_mac_addr   = 48'h112233445566;
        in_lg_time_slot_period  = 32'h7a12;
        in_local_mac_id         = 48'h0000deadbeef;
        tick(1'b1, 1'b0);
        in_lg_dst_mac = 48'h0;
        in_lg_time_slot_period = 32'h0;
        chk("s_head", out_lg_data, {2'b01, 4'h0, 8'd13, 12'h0, 12'd208, 96'h0});
        for (int b = 1; b <= 12; b++) begin
            tick(1'b0, 1'b0);
            chk("s_wr", {133'h0, out_lg_data_wr}, 134'd1);
            if (b == 2) chk("s_b2", out_lg_data,
                {2'b11, 4'h0, 48'h0a0b0c0d0e0f, 48'h0000deadbeef, 16'h1662, 4'h0, 4'hf, 8'h0});
            if (b == 6) chk("s_b6", out_lg_data,
                {2'b11, 4'h0, 48'h112233445566, 1'b1, 15'd1, 32'h20, 32'h7a12});
        end
        chk("s_tail", out_lg_data, {2'b10, 132'h0});
        chk("s_tail_strobes", {131'h0, out_lg_data_valid, out_lg_data_valid_wr, out_lg_done}, 134'h7);
        chk("s_seq", {119'h0, out_lg_seq}, 134'd1);
        tick(1'b0, 1'b0);
        chk("s_idle", {132'h0, out_lg_data_wr, out_lg_busy}, '0);

        // Backpressure: alf high for 20 cycles, then toggled mid-packet.
        rand_cfg();
        tick(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b1);
            chk("bp_hold", {132'h0, out_lg_data_wr, out_lg_busy}, 134'd1);
        end
        tick(1'b0, 1'b0);
        chk("bp_head", {132'h0, out_lg_data[133:132]}, {132'h0, 2'b01});
        for (int b = 1; b <= 12; b++) begin
            tick(1'b0, 1'($urandom));
            chk("bp_wr", {133'h0, out_lg_data_wr}, 134'd1);
        end
        chk("bp_seq", {119'h0, out_lg_seq}, 134'd2);
        tick(1'b0, 1'b0);

        // Back-to-back: two more triggers during the packet, last wins.
        rand_cfg();
        in_lg_time_slot_period = 32'h80;
        tick(1'b1, 1'b0);
        for (int b = 1; b <= 12; b++) begin
            bit t;
            t = (b == 6) || (b == 9);
            if (b == 6) in_lg_time_slot_period = 32'h100;
            if (b == 9) in_lg_time_slot_period = 32'h200;
            tick(t, 1'b0);
            if (b == 6) chk("bb_b6_first", {102'h0, out_lg_data[31:0]}, 134'h80);
        end
        in_lg_time_slot_period = 32'h0;
        chk("bb_tail1", {119'h0, out_lg_seq}, 134'd3);
        tick(1'b0, 1'b0);
        chk("bb_gap", {132'h0, out_lg_data_wr, out_lg_busy}, 134'd1);
        tick(1'b0, 1'b0);
        chk("bb_head2", {132'h0, out_lg_data[133:132]}, {132'h0, 2'b01});
        for (int b = 1; b <= 12; b++) begin
            tick(1'b0, 1'b0);
            if (b == 6) chk("bb_b6_second", {102'h0, out_lg_data[31:0]}, 134'h200);
        end
        chk("bb_seq", {119'h0, out_lg_seq}, 134'd4);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("bb_only_two", {132'h0, out_lg_data_wr, out_lg_busy}, '0);

        // Trigger coincident with the tail.
        rand_cfg();
        tick(1'b1, 1'b0);
        for (int b = 1; b <= 12; b++) tick(1'b0, 1'b0);
        chk("tc_tail", {133'h0, out_lg_done}, 134'd1);
        rand_cfg();
        tick(1'b1, 1'b0);
        chk("tc_pending", {132'h0, out_lg_data_wr, out_lg_busy}, 134'd1);
        tick(1'b0, 1'b0);
        chk("tc_head", {132'h0, out_lg_data[133:132]}, {132'h0, 2'b01});
        for (int b = 1; b <= 12; b++) tick(1'b0, 1'b0);
        chk("tc_seq", {119'h0, out_lg_seq}, 134'd6);
        tick(1'b0, 1'b0);

        // Asynchronous reset at beat 7.
        rand_cfg();
        tick(1'b1, 1'b0);
        for (int b = 1; b <= 7; b++) tick(1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_data", out_lg_data, '0);
        chk("mr_flags", {129'h0, out_lg_data_wr, out_lg_data_valid, out_lg_data_valid_wr,
                         out_lg_done, out_lg_busy}, '0);
        chk("mr_seq", {119'h0, out_lg_seq}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b0);
        rand_cfg();
        send_one("mr_after", 15'd1, 15'd1);

        // Sequence wrap, with the counter preloaded just below the top.
        preload_now = 1'b1;
        #2 force dut.seq_q = 15'h7ffe;
        #1 release dut.seq_q;
        rand_cfg();
        send_one("wrap_a", 15'h7fff, 15'h7fff);
        rand_cfg();
        send_one("wrap_b", 15'h0000, 15'h0000);

        // Randomized traffic checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            rand_cfg();
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < 40; k++) tick(1'b0, 1'b0);
        chk("drain_busy", {133'h0, out_lg_busy}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
